// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 4-digit 7-segment scan driver.
//   SEG_ZERO    - pattern for numeral 0 (bit 6 = seg a ... bit 0 = seg g, active-high)
//   SEG_OFF     - pattern with every segment dark (before polarity is applied)
//   NUM_DIGITS  - digits on the panel
//   seg_state_e - scan slot phase: StDead (all anodes off) / StShow (one digit lit)
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [6:0]  SEG_ZERO   = 7'h7E;
    localparam logic [6:0]  SEG_OFF    = 7'h00;

    typedef enum logic {
        StDead = 1'b0,
        StShow = 1'b1
    } seg_state_e;

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: prescaler, digit index and DEAD/SHOW slot decode for the scan driver.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   en_i          - scan enable; low holds the scan at digit 0, DEAD phase
//   digit_o       - digit currently being scanned
//   show_o        - current slot is in its SHOW phase
//   wrap_o        - this cycle is the digit 3 -> digit 0 wrap (frame boundary)
//   frame_done_o  - registered one-cycle pulse following the wrap
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYC    = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    output logic [1:0] digit_o,
    output logic       show_o,
    output logic       wrap_o,
    output logic       frame_done_o
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD = PW'(DEAD_CYC);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    seg_state_e    state_q, state_d;
    logic          frame_done_q, frame_done_d;
    logic          terminal;

    always_comb begin
        terminal     = (presc_q == TERM);
        presc_d      = presc_q + PW'(1);
        digit_d      = digit_q;
        frame_done_d = 1'b0;
        if (!en_i) begin
            presc_d = '0;
            digit_d = '0;
        end else if (terminal) begin
            presc_d      = '0;
            digit_d      = digit_q + 2'd1;
            frame_done_d = (digit_q == 2'd3);
        end
        // State tracks the prescaler value it will sit beside next cycle.
        state_d = (presc_d < DEAD) ? StDead : StShow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            digit_q      <= '0;
            state_q      <= StDead;
            frame_done_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign digit_o      = digit_q;
    assign show_o       = (state_q == StShow);
    assign wrap_o       = en_i && terminal && (digit_q == 2'd3);
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 4-digit 7-segment display driver with dead time
// between digits and frame-atomic display updates.
// Optional feature: define SEG_SCAN_BLANK_LZ_EN for leading-zero blanking.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - display enable; low blanks and restarts the scan at digit 0
//   load        - strobe capturing seg_in into the pending register
//   seg_in      - packed patterns, [27:21] digit3 ... [6:0] digit0
//   seg_out     - shared segment bus (inverted when SEG_ACTIVE_LOW)
//   an_n        - active-low anode enables, an_n[k] = digit k
//   frame_done  - one-cycle pulse when the digit-3 slot ends
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 100000,
    parameter int unsigned DEAD_CYC       = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [27:0] seg_in,
    output logic [6:0]  seg_out,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    logic [27:0] pending_q, pending_d;
    logic [27:0] active_q, active_d;
    logic        pend_valid_q, pend_valid_d;
    logic [3:0]  an_n_q, an_n_d;
    logic [6:0]  seg_out_q, seg_out_d;

    logic [1:0]            digit;
    logic                  show;
    logic                  wrap;
    logic [6:0]            pat [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank;

    seg_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYC    (DEAD_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en),
        .digit_o      (digit),
        .show_o       (show),
        .wrap_o       (wrap),
        .frame_done_o (frame_done)
    );

    // Transfer reads the old pending before a coincident load overwrites it,
    // so a load on the wrap cycle waits for the following frame.
    always_comb begin
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        active_d     = active_q;
        if (wrap && pend_valid_q) begin
            active_d     = pending_q;
            pend_valid_d = 1'b0;
        end
        if (load) begin
            pending_d    = seg_in;
            pend_valid_d = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            pat[k] = active_q[7*k +: 7];
        end
    end

`ifdef SEG_SCAN_BLANK_LZ_EN
    // A digit is blanked only if it and every higher digit show numeral 0.
    always_comb begin
        blank    = '0;
        blank[3] = (pat[3] == SEG_ZERO);
        blank[2] = blank[3] && (pat[2] == SEG_ZERO);
        blank[1] = blank[2] && (pat[1] == SEG_ZERO);
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    // en is folded in so the outputs go dark on the first edge with en low.
    always_comb begin
        an_n_d    = 4'hF;
        seg_out_d = SEG_BLANK;
        if (en && show && !blank[digit]) begin
            an_n_d    = ~(4'b0001 << digit);
            seg_out_d = SEG_ACTIVE_LOW ? ~pat[digit] : pat[digit];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            active_q     <= '0;
            pend_valid_q <= 1'b0;
            an_n_q       <= 4'hF;
            seg_out_q    <= SEG_BLANK;
        end else begin
            pending_q    <= pending_d;
            active_q     <= active_d;
            pend_valid_q <= pend_valid_d;
            an_n_q       <= an_n_d;
            seg_out_q    <= seg_out_d;
        end
    end

    assign an_n    = an_n_q;
    assign seg_out = seg_out_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: directed self-checking bench for seg_scan_mux with
// REFRESH_DIV=8, DEAD_CYC=2, SEG_ACTIVE_LOW=1 (32-cycle frames).
module tb_seg_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [27:0] seg_in;
    logic [6:0]  seg_out;
    logic [3:0]  an_n;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Patterns packed digit3..digit0.
    localparam logic [27:0] P0 = {7'h79, 7'h6D, 7'h30, 7'h7E};
    localparam logic [27:0] P1 = {7'h7F, 7'h5B, 7'h33, 7'h70};
    localparam logic [27:0] P2 = {7'h30, 7'h30, 7'h30, 7'h30};
    localparam logic [27:0] P3 = {7'h6D, 7'h79, 7'h33, 7'h5B};
    localparam logic [27:0] P4 = {7'h5F, 7'h70, 7'h7F, 7'h7B};
    localparam logic [27:0] P5 = {7'h7B, 7'h30, 7'h6D, 7'h79};
    localparam logic [27:0] P6 = {7'h33, 7'h5B, 7'h5F, 7'h70};
    localparam logic [27:0] P7 = {7'h6D, 7'h6D, 7'h6D, 7'h30};
    localparam logic [27:0] PZ = {7'h7E, 7'h7E, 7'h30, 7'h7E};

    always #5 clk = ~clk;

    seg_scan_mux #(
        .REFRESH_DIV    (8),
        .DEAD_CYC       (2),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Outputs sampled after edge n reflect scan position m = n-1.
    function automatic logic [3:0] exp_an(input int m);
        if (m % 8 < 2) return 4'hF;
        return ~(4'b0001 << ((m / 8) % 4));
    endfunction

    function automatic logic [6:0] exp_seg(input int m, input logic [27:0] p);
        int d;
        if (m % 8 < 2) return 7'h7F;
        d = (m / 8) % 4;
        return ~p[7*d +: 7];
    endfunction

    // Pattern on display in frame f (frame covers m = 32f .. 32f+31).
    function automatic logic [27:0] frame_pat(input int f);
        case (f)
            2:       return P0;
            3:       return P1;
            4:       return P3;
            5:       return P5;
            6:       return P4;
            default: return 28'h0;
        endcase
    endfunction

    task automatic test_reset();
        rst_n  = 1'b0;
        en     = 1'b1;
        load   = 1'b0;
        seg_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (an_n !== 4'hF) begin
            n_errors++; $display("FAIL reset_an_n: got %h expected f", an_n);
        end
        n_checks++;
        if (seg_out !== 7'h7F) begin
            n_errors++; $display("FAIL reset_seg_out: got %h expected 7f", seg_out);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done);
        end
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 32) begin
            tick();
            n_checks++;
            if (an_n !== exp_an(cyc - 1)) begin
                n_errors++;
                $display("FAIL idle_scan_an cyc=%0d: got %h expected %h", cyc, an_n, exp_an(cyc - 1));
            end
            n_checks++;
            if (frame_done !== (cyc % 32 == 0)) begin
                n_errors++;
                $display("FAIL idle_frame_done cyc=%0d: got %b", cyc, frame_done);
            end
        end
    endtask

    task automatic test_atomic_load();
        while (cyc < 104) begin
            load   = (cyc == 32) || (cyc == 76);
            seg_in = (cyc == 76) ? P1 : P0;
            tick();
            n_checks++;
            if (an_n !== exp_an(cyc - 1)) begin
                n_errors++;
                $display("FAIL atomic_an cyc=%0d: got %h expected %h", cyc, an_n, exp_an(cyc - 1));
            end
            n_checks++;
            if (seg_out !== exp_seg(cyc - 1, frame_pat((cyc - 1) / 32))) begin
                n_errors++;
                $display("FAIL atomic_seg cyc=%0d: got %h expected %h", cyc, seg_out,
                         exp_seg(cyc - 1, frame_pat((cyc - 1) / 32)));
            end
            n_checks++;
            if (frame_done !== (cyc % 32 == 0)) begin
                n_errors++;
                $display("FAIL atomic_frame_done cyc=%0d: got %b", cyc, frame_done);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        while (cyc < 200) begin
            load = (cyc == 105) || (cyc == 110) || (cyc == 140) || (cyc == 159);
            case (cyc)
                105:     seg_in = P2;
                110:     seg_in = P3;
                140:     seg_in = P5;
                default: seg_in = P4;
            endcase
            tick();
            n_checks++;
            if (an_n !== exp_an(cyc - 1)) begin
                n_errors++;
                $display("FAIL b2b_an cyc=%0d: got %h expected %h", cyc, an_n, exp_an(cyc - 1));
            end
            n_checks++;
            if (seg_out !== exp_seg(cyc - 1, frame_pat((cyc - 1) / 32))) begin
                n_errors++;
                $display("FAIL b2b_seg cyc=%0d: got %h expected %h", cyc, seg_out,
                         exp_seg(cyc - 1, frame_pat((cyc - 1) / 32)));
            end
        end
        load = 1'b0;
    endtask

    task automatic test_enable();
        while (cyc < 212) tick();
        // Mid-SHOW of digit 2, pattern P4 digit2 = 70.
        n_checks++;
        if (an_n !== 4'hB || seg_out !== 7'h0F) begin
            n_errors++;
            $display("FAIL en_pre_show: got an_n=%h seg=%h expected b/0f", an_n, seg_out);
        end
        en = 1'b0;
        tick();
        n_checks++;
        if (an_n !== 4'hF || seg_out !== 7'h7F) begin
            n_errors++;
            $display("FAIL en_drop_blank: got an_n=%h seg=%h expected f/7f", an_n, seg_out);
        end
        load   = 1'b1;
        seg_in = P6;
        tick();
        load = 1'b0;
        tick();
        n_checks++;
        if (an_n !== 4'hF || frame_done !== 1'b0) begin
            n_errors++;
            $display("FAIL en_low_hold: got an_n=%h fd=%b expected f/0", an_n, frame_done);
        end
        en = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k <= 2) begin
                n_checks++;
                if (an_n !== 4'hF) begin
                    n_errors++; $display("FAIL en_restart_dead k=%0d: got %h expected f", k, an_n);
                end
            end
            if (k == 3) begin
                // Old active (P4) still shown: P6 is pending until the next wrap.
                n_checks++;
                if (an_n !== 4'hE || seg_out !== 7'h04) begin
                    n_errors++;
                    $display("FAIL en_restart_show: got an_n=%h seg=%h expected e/04", an_n, seg_out);
                end
            end
            if (k == 31 || k == 32) begin
                n_checks++;
                if (frame_done !== (k == 32)) begin
                    n_errors++; $display("FAIL en_frame_done k=%0d: got %b", k, frame_done);
                end
            end
            if (k == 35) begin
                n_checks++;
                if (an_n !== 4'hE || seg_out !== 7'h0F) begin
                    n_errors++;
                    $display("FAIL en_first_transfer: got an_n=%h seg=%h expected e/0f", an_n, seg_out);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        load   = 1'b1;
        seg_in = P7;
        tick();
        load = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (an_n !== 4'hF || seg_out !== 7'h7F) begin
            n_errors++;
            $display("FAIL async_reset_blank: got an_n=%h seg=%h expected f/7f", an_n, seg_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        while (cyc < 35) begin
            tick();
            if (cyc == 3 || cyc == 35) begin
                // Pending P7 must be gone: digit 0 shows the cleared active value.
                n_checks++;
                if (an_n !== 4'hE || seg_out !== 7'h7F) begin
                    n_errors++;
                    $display("FAIL async_pending_lost cyc=%0d: got an_n=%h seg=%h expected e/7f",
                             cyc, an_n, seg_out);
                end
            end
        end
    endtask

    task automatic test_blank();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic [6:0] dpat;
        load   = 1'b1;
        seg_in = PZ;
        tick();
        load = 1'b0;
        while (cyc < 96) begin
            tick();
            for (int k = 0; k < 4; k++) begin
                if (cyc == 67 + 8 * k) begin
                    dpat  = PZ[7*k +: 7];
                    e_an  = ~(4'b0001 << k);
                    e_seg = ~dpat;
`ifdef SEG_SCAN_BLANK_LZ_EN
                    if (k >= 2) begin
                        e_an  = 4'hF;
                        e_seg = 7'h7F;
                    end
`endif
                    n_checks++;
                    if (an_n !== e_an || seg_out !== e_seg) begin
                        n_errors++;
                        $display("FAIL blank_digit%0d: got an_n=%h seg=%h expected %h/%h",
                                 k, an_n, seg_out, e_an, e_seg);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_atomic_load();
        test_back_to_back();
        test_enable();
        test_async_reset();
        test_blank();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
